pi_digit_decoder: RTL and testbench

Consumer at the far end of the pi-series accumulator: accepts one unsigned fixed-point value (integer plus fraction), converts it to decimal digits, and emits them most-significant first over a valid/ready stream. A 7-segment pattern of the current digit is also driven for the board display. It sits between the series accumulator's result register and the SEG/LCD output logic. Each fractional digit comes from one ×10 step per digit, so no divider is needed.

---
 rtl/pi_digit_decoder_if.sv | 29 ++
 rtl/pi_digit_decoder.sv | 98 +++++++++
 tb/tb_pi_digit_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pi_digit_decoder_if.sv
// Stream bundle between the value source, the digit decoder and the display/consumer.
// Input value handshake (in_*) and digit output stream (digit_*) plus the 7-seg pattern.
interface pi_digit_decoder_if #(
  parameter int INT_BITS  = 4,
  parameter int FRAC_BITS = 48
);
  logic [INT_BITS+FRAC_BITS-1:0] in_value;
  logic                          in_valid;
  logic                          in_ready;
  logic [3:0]                    digit;
  logic                          digit_valid;
  logic                          digit_ready;
  logic                          digit_last;
  logic                          overflow;
  logic [7:0]                    seg;
  logic                          dbg_state;

  // Source/consumer side of the decoder.
  modport master (
    output in_value, in_valid, digit_ready,
    input  in_ready, digit, digit_valid, digit_last, overflow, seg, dbg_state
  );

  // Decoder side.
  modport slave (
    input  in_value, in_valid, digit_ready,
    output in_ready, digit, digit_valid, digit_last, overflow, seg, dbg_state
  );
endinterface

// File: rtl/pi_digit_decoder.sv
// Converts one unsigned fixed-point value into NDIGITS decimal digits, MSD first,
// using one x10 shift-add step per fractional digit; also drives a 7-seg pattern.
module pi_digit_decoder #(
  parameter int INT_BITS  = 4,
  parameter int FRAC_BITS = 48,
  parameter int NDIGITS   = 12
) (
  input  logic              clk_2,
  input  logic              reset,
  pi_digit_decoder_if.slave bus
);
  localparam int CW = (NDIGITS > 2) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t                 state_q;
  logic [FRAC_BITS-1:0]   frac_q;
  logic [3:0]             digit_q;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;

  logic [INT_BITS-1:0]    int_part;
  logic                   int_ovf;
  logic [FRAC_BITS+3:0]   frac_ext;
  logic [FRAC_BITS+3:0]   prod;
  logic [6:0]             seg_raw;

  assign int_part = bus.in_value[INT_BITS+FRAC_BITS-1:FRAC_BITS];
  assign int_ovf  = (32'(int_part) >= 32'd10);

  // frac*10 as (frac<<3)+(frac<<1); the top 4 bits are the next digit (always 0-9).
  assign frac_ext = {4'b0000, frac_q};
  assign prod     = (frac_ext << 3) + (frac_ext << 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready. While
  // digit_valid is high and digit_ready low, digit/seg/digit_last hold stable.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      frac_q  <= '0;
      digit_q <= 4'h0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            frac_q  <= bus.in_value[FRAC_BITS-1:0];
            digit_q <= int_ovf ? 4'hF : 4'(int_part);
            ovf_q   <= int_ovf;
            cnt_q   <= '0;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.digit_ready) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= S_IDLE;
            end else begin
              digit_q <= prod[FRAC_BITS+3:FRAC_BITS];
              frac_q  <= prod[FRAC_BITS-1:0];
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    seg_raw = 7'h00;
    case (digit_q)
      4'h0: seg_raw = 7'h3F;
      4'h1: seg_raw = 7'h06;
      4'h2: seg_raw = 7'h5B;
      4'h3: seg_raw = 7'h4F;
      4'h4: seg_raw = 7'h66;
      4'h5: seg_raw = 7'h6D;
      4'h6: seg_raw = 7'h7D;
      4'h7: seg_raw = 7'h07;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h6F;
      4'hF: seg_raw = 7'h79;
      default: seg_raw = 7'h00;
    endcase
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.digit_valid = (state_q == S_EMIT);
  assign bus.digit       = digit_q;
  assign bus.digit_last  = (state_q == S_EMIT) && (cnt_q == LAST_CNT);
  assign bus.overflow    = ovf_q;
  // Decimal point marks the integer digit; display blanks when nothing is valid.
  assign bus.seg         = (state_q == S_EMIT) ? {(cnt_q == '0), seg_raw} : 8'h00;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_pi_digit_decoder.sv
// Bench for pi_digit_decoder: directed spec cases plus randomized values with
// random backpressure, checked against an arithmetic digit-expansion model.
module tb_pi_digit_decoder;
  localparam int IB = 4;
  localparam int FB = 48;
  localparam int ND = 12;
  localparam int W  = IB + FB;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  always #5 clk_2 = ~clk_2;

  pi_digit_decoder_if #(.INT_BITS(IB), .FRAC_BITS(FB)) bus ();

  pi_digit_decoder #(.INT_BITS(IB), .FRAC_BITS(FB), .NDIGITS(ND)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic       exp_ovf;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h79};
    return t[d];
  endfunction

  // Reference: integer part as a decimal digit, then repeated frac*10 digit extraction.
  task automatic build_exp(input logic [W-1:0] v);
    logic [63:0] f;
    logic [63:0] p;
    int ip;
    exp_q.delete();
    ip = int'(v >> FB);
    exp_ovf = (ip >= 10);
    exp_q.push_back(exp_ovf ? 4'hF : 4'(ip));
    f = 64'(v) % (64'd1 << FB);
    for (int i = 1; i < ND; i++) begin
      p = f * 64'd10;
      exp_q.push_back(4'(p / (64'd1 << FB)));
      f = p % (64'd1 << FB);
    end
  endtask

  // Called right after the accepting edge; checks each presented digit and pops on handshake.
  // mode 0: ready always 1, 1: ready pattern 1,0,0, 2: random. abort_after>0 stops early.
  task automatic consume(input string name, input int mode, input bit poke, input int abort_after);
    int cyc = 0;
    int popped = 0;
    int phase = 0;
    logic rdy;
    logic [7:0] exp_seg;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk_2);
      cyc++;
      total++;
      if (bus.digit_valid !== 1'b1 || bus.digit !== exp_q[0]) begin
        bad++;
        $display("FAIL %s digit[%0d]: got valid=%b digit=%h want valid=1 digit=%h",
                 name, popped, bus.digit_valid, bus.digit, exp_q[0]);
      end
      exp_seg = {(popped == 0), seg_pat(exp_q[0])};
      total++;
      if (bus.seg !== exp_seg) begin
        bad++;
        $display("FAIL %s seg[%0d]: got %h want %h", name, popped, bus.seg, exp_seg);
      end
      total++;
      if ({bus.digit_last, bus.overflow, bus.in_ready} !== {(exp_q.size() == 1), exp_ovf, 1'b0}) begin
        bad++;
        $display("FAIL %s flags[%0d]: got last/ovf/in_ready=%b%b%b want %b%b0", name, popped,
                 bus.digit_last, bus.overflow, bus.in_ready, (exp_q.size() == 1), exp_ovf);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (phase % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (poke) begin
        bus.in_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_value = {4'($urandom_range(0, 15)), 32'($urandom), 16'($urandom)};
      end
      bus.digit_ready = rdy;
      if (rdy) begin
        void'(exp_q.pop_front());
        popped++;
        if (abort_after > 0 && popped == abort_after) return;
      end
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d digits left want 0", name, exp_q.size());
    end
  endtask

  task automatic send_value(input string name, input logic [W-1:0] v, input int mode, input bit poke);
    build_exp(v);
    @(negedge clk_2);
    total++;
    if ({bus.in_ready, bus.digit_valid, bus.digit_last, bus.seg} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL %s idle: got in_ready=%b valid=%b last=%b seg=%h want 1 0 0 00",
               name, bus.in_ready, bus.digit_valid, bus.digit_last, bus.seg);
    end
    bus.in_value = v;
    bus.in_valid = 1'b1;
    @(posedge clk_2);
    #1 bus.in_valid = 1'b0;
    consume(name, mode, poke, 0);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({bus.in_ready, bus.digit_valid, bus.digit, bus.digit_last, bus.overflow, bus.seg, bus.dbg_state}
        !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset: got rdy=%b val=%b d=%h last=%b ovf=%b seg=%h st=%b want 1 0 0 0 0 00 0",
               bus.in_ready, bus.digit_valid, bus.digit, bus.digit_last, bus.overflow, bus.seg, bus.dbg_state);
    end
    @(negedge clk_2);
    reset = 1'b1;
  endtask

  task automatic test_pi();
    send_value("pi", 52'h3_243F_6A88_85A3, 0, 1'b0);
  endtask

  task automatic test_one_point_five();
    send_value("one_half", 52'h1_8000_0000_0000, 0, 1'b0);
  endtask

  task automatic test_overflow();
    send_value("ovf", 52'hC_0000_0000_0000, 0, 1'b0);
    send_value("ovf_clear", 52'h2_0000_0000_0000, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_value("bp_pi", 52'h3_243F_6A88_85A3, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    build_exp(52'h3_243F_6A88_85A3);
    @(negedge clk_2);
    bus.in_value = 52'h3_243F_6A88_85A3;
    bus.in_valid = 1'b1;
    @(posedge clk_2);
    #1 bus.in_valid = 1'b0;
    consume("rst_mid", 0, 1'b0, 4);
    @(posedge clk_2);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.digit_valid, bus.seg, bus.in_ready, bus.digit_last} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid abort: got valid=%b seg=%h in_ready=%b last=%b want 0 00 1 0",
               bus.digit_valid, bus.seg, bus.in_ready, bus.digit_last);
    end
    @(negedge clk_2);
    @(negedge clk_2);
    reset = 1'b1;
    send_value("after_rst", 52'h0_4000_0000_0000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    build_exp(52'h1_8000_0000_0000);
    @(negedge clk_2);
    bus.in_value = 52'h1_8000_0000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk_2);
    #1 bus.in_value = 52'h3_243F_6A88_85A3;
    consume("b2b_first", 0, 1'b0, 0);
    @(negedge clk_2);
    total++;
    if ({bus.in_ready, bus.digit_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b gap: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.digit_valid);
    end
    build_exp(52'h3_243F_6A88_85A3);
    @(posedge clk_2);
    #1 bus.in_valid = 1'b0;
    consume("b2b_second", 0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = {4'($urandom_range(0, 15)), 32'($urandom), 16'($urandom)};
      send_value("rand", v, 2, 1'b1);
    end
  endtask

  initial begin
    bus.in_value    = '0;
    bus.in_valid    = 1'b0;
    bus.digit_ready = 1'b0;
    test_reset();
    test_pi();
    test_one_point_five();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk_2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
